gf2m_reduce_seq: RTL and testbench

- Sequential GF(2^11) polynomial reduction stage. Sits directly downstream of the 11x11 carry-less Karatsuba multiplier.
- Takes the 21-bit unreduced product and reduces it modulo the irreducible trinomial x^11 + x^2 + 1, yielding the 11-bit field element.
- Processes one high-order bit per cycle behind a valid/ready handshake on both sides.

---
 rtl/gf2m_reduce_seq_pkg.sv | 21 ++
 rtl/gf2m_reduce_seq_if.sv | 22 ++
 rtl/gf2m_reduce_seq_step.sv | 23 ++
 rtl/gf2m_reduce_seq.sv | 77 +++++++
 tb/tb_gf2m_reduce_seq.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/gf2m_reduce_seq_pkg.sv
// Shared constants and types for the GF(2^11) reduction stage (x^11 + x^2 + 1).
package gf2m_pkg;

    localparam int M     = 11;
    localparam int N     = 2 * M - 1;
    localparam int IDX_W = $clog2(N);

    localparam logic [M-1:0] POLY      = 11'h005;
    localparam logic [M:0]   POLY_FULL = {1'b1, POLY};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REDUCE = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef logic [N-1:0]     prod_t;
    typedef logic [M-1:0]     elem_t;
    typedef logic [IDX_W-1:0] idx_t;

endpackage

// File: rtl/gf2m_reduce_seq_if.sv
// Input/output valid-ready bus of the GF(2^11) reduction stage.
interface gf2m_reduce_seq_if;
    import gf2m_pkg::*;

    logic  in_valid;
    logic  in_ready;
    prod_t in_prod;
    logic  out_valid;
    logic  out_ready;
    elem_t out_rem;

    modport master (
        output in_valid, in_prod, out_ready,
        input  in_ready, out_valid, out_rem
    );

    modport slave (
        input  in_valid, in_prod, out_ready,
        output in_ready, out_valid, out_rem
    );

endinterface

// File: rtl/gf2m_reduce_seq_step.sv
// One bit-serial reduction step: cancels bit idx of r with the shifted modulus.
module gf2m_reduce_step
    import gf2m_pkg::*;
(
    input  prod_t r,
    input  idx_t  idx,
    output prod_t r_next
);

    idx_t  shamt;
    prod_t tap;

    always_comb begin
        shamt  = idx - IDX_W'(M);
        tap    = prod_t'(POLY_FULL) << shamt;
        r_next = r;
        // Only indices in the high half carry a tap; lower bits are the result.
        if ((idx >= IDX_W'(M)) && r[idx]) begin
            r_next = r ^ tap;
        end
    end

endmodule

// File: rtl/gf2m_reduce_seq.sv
// Sequential GF(2^11) reduction, one high-order bit per cycle behind valid/ready.
// Optional macro GF2M_RED_SKIP_EN: finish early once the high half of r is clear.
module gf2m_reduce_seq
    import gf2m_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    gf2m_reduce_seq_if.slave    bus,
    output logic                busy
);

    state_t state_q, state_d;
    prod_t  r_q, r_d;
    idx_t   idx_q, idx_d;
    prod_t  r_step;

    gf2m_reduce_step u_step (
        .r      (r_q),
        .idx    (idx_q),
        .r_next (r_step)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            r_q     <= '0;
            idx_q   <= IDX_W'(N - 1);
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    r_d     = bus.in_prod;
                    idx_d   = IDX_W'(N - 1);
                    state_d = REDUCE;
                end
            end
            REDUCE: begin
`ifdef GF2M_RED_SKIP_EN
                if (r_q[N-1:M] == '0) begin
                    state_d = DONE;
                end else begin
                    r_d = r_step;
                    if (idx_q == IDX_W'(M)) state_d = DONE;
                    else                    idx_d   = idx_q - 1'b1;
                end
`else
                r_d = r_step;
                if (idx_q == IDX_W'(M)) state_d = DONE;
                else                    idx_d   = idx_q - 1'b1;
`endif
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Result leaves straight from the working register; no extra output flop.
    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
        bus.out_rem   = r_q[M-1:0];
        busy          = (state_q != IDLE);
    end

endmodule

// File: tb/tb_gf2m_reduce_seq.sv
// Directed and random checks of gf2m_reduce_seq against hand values and a bit-serial model.
module tb_gf2m_reduce_seq;
    import gf2m_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    int   checks = 0;
    int   errors = 0;

`ifdef GF2M_RED_SKIP_EN
    localparam int LAT_PASS = 1;
`else
    localparam int LAT_PASS = 10;
`endif
    localparam int LAT_FULL = 10;

    gf2m_reduce_seq_if bus ();

    gf2m_reduce_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] ref_mod(input logic [20:0] p);
        logic [20:0] v;
        v = p;
        for (int i = 20; i >= 11; i--) begin
            if (v[i]) v = v ^ (21'h000805 << (i - 11));
        end
        return v[10:0];
    endfunction

    // Present p in IDLE; returns after the accepting edge (+1).
    task automatic accept(input logic [20:0] p);
        bus.in_valid = 1'b1;
        bus.in_prod  = p;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    // Cycles from acceptance until out_valid is seen; -1 on timeout.
    task automatic wait_valid(output int cnt);
        cnt = 0;
        while (!bus.out_valid && cnt < 40) begin
            @(posedge clk); #1;
            cnt++;
        end
        if (!bus.out_valid) cnt = -1;
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic run_one(input string name, input logic [20:0] p,
                           input logic [10:0] exp, input int exp_lat);
        int lat;
        accept(p);
        wait_valid(lat);
        checks++;
        if (lat < 0) begin
            errors++;
            $display("FAIL %s timeout: out_valid never rose", name);
        end else if (exp_lat >= 0 && lat != exp_lat) begin
            errors++;
            $display("FAIL %s latency got %0d want %0d", name, lat, exp_lat);
        end
        checks++;
        if (bus.out_rem !== exp) begin
            errors++;
            $display("FAIL %s out_rem got %h want %h", name, bus.out_rem, exp);
        end
        consume();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s after handshake valid=%b ready=%b want 0/1",
                     name, bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || busy !== 1'b0 ||
            bus.out_rem !== 11'h000) begin
            errors++;
            $display("FAIL reset_state ready=%b valid=%b busy=%b rem=%h want 1/0/0/000",
                     bus.in_ready, bus.out_valid, busy, bus.out_rem);
        end
    endtask

    task automatic test_reset_mid_op();
        bit seen;
        accept(21'h000800);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid valid=%b ready=%b busy=%b want 0/1/0",
                     bus.out_valid, bus.in_ready, busy);
        end
        @(negedge clk) rst_n = 1'b1;
        bus.out_ready = 1'b1;
        seen = 1'b0;
        repeat (15) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen = 1'b1;
        end
        bus.out_ready = 1'b0;
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL reset_mid_discard out_valid got 1 want 0");
        end
        run_one("after_reset_x12", 21'h001000, 11'h00A, LAT_FULL);
    endtask

    task automatic test_single_bit();
        run_one("x11", 21'h000800, 11'h005, LAT_FULL);
    endtask

    task automatic test_top_bits();
        run_one("x20", 21'h100000, 11'h205, -1);
        run_one("x20_x11", 21'h100800, 11'h200, -1);
    endtask

    task automatic test_passthrough();
        run_one("pass_7ff", 21'h0007FF, 11'h7FF, LAT_PASS);
        run_one("zero", 21'h000000, 11'h000, LAT_PASS);
    endtask

    task automatic test_backpressure();
        int lat;
        accept(21'h100000);
        wait_valid(lat);
        checks++;
        if (lat < 0) begin
            errors++;
            $display("FAIL bp timeout: out_valid never rose");
        end
        bus.in_prod = 21'h100000;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = i[0];
            @(posedge clk); #1;
            checks++;
            if (bus.out_rem !== 11'h205 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold%0d rem=%h ready=%b valid=%b want 205/0/1",
                         i, bus.out_rem, bus.in_ready, bus.out_valid);
            end
        end
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_release ready=%b busy=%b want 1/0", bus.in_ready, busy);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_second_accept busy=%b ready=%b want 1/0", busy, bus.in_ready);
        end
        wait_valid(lat);
        checks++;
        if (lat < 0 || bus.out_rem !== 11'h205) begin
            errors++;
            $display("FAIL bp_second_result rem=%h lat=%0d want 205", bus.out_rem, lat);
        end
        consume();
    endtask

    task automatic test_random();
        logic [20:0] p;
        logic [10:0] exp;
        int lat;
        int stall;
        for (int n = 0; n < 1000; n++) begin
            p = 21'($urandom());
            if (n % 8 == 0) p = p & 21'h0007FF;
            exp = ref_mod(p);
            accept(p);
            wait_valid(lat);
            checks++;
            if (lat < 0 || lat > LAT_FULL || bus.out_rem !== exp) begin
                errors++;
                $display("FAIL rand%0d in=%h rem=%h want %h lat=%0d", n, p, bus.out_rem, exp, lat);
            end
            stall = $urandom_range(0, 3);
            for (int s = 0; s < stall; s++) begin
                @(posedge clk); #1;
                if (bus.out_valid !== 1'b1 || bus.out_rem !== exp) begin
                    checks++;
                    errors++;
                    $display("FAIL rand_stall%0d valid=%b rem=%h want 1/%h",
                             n, bus.out_valid, bus.out_rem, exp);
                end
            end
            consume();
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL rand_single%0d extra out_valid", n);
            end
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_prod   = '0;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset_mid_op();
        test_single_bit();
        test_top_bits();
        test_passthrough();
        test_backpressure();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
